// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared types and encodings for the ARM pipeline hazard controller
package arm_pipe_pkg;

  localparam int REG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline stage observation and hazard control bundle
interface pipeline_hazard_ctrl_if
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [REG_W-1:0] id_src1;
  logic             id_src1_vld;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_vld;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [REG_W-1:0] exe_src1;
  logic [REG_W-1:0] exe_src2;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic [REG_W-1:0] wb_dest;
  logic             wb_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             hazard;
  logic             freeze;
  logic             flush;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_src1, id_src1_vld, id_src2, id_src2_vld, exe_dest, exe_wb_en, exe_mem_r_en,
           exe_src1, exe_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en, branch_taken,
           mem_req, sram_ready,
    input  hazard, freeze, flush, fwd_sel_a, fwd_sel_b, stall_count
  );

  modport slave (
    input  id_src1, id_src1_vld, id_src2, id_src2_vld, exe_dest, exe_wb_en, exe_mem_r_en,
           exe_src1, exe_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en, branch_taken,
           mem_req, sram_ready,
    output hazard, freeze, flush, fwd_sel_a, fwd_sel_b, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// rtl/pipeline_hazard_ctrl_forward_unit.sv - EXE operand bypass select, MEM result preferred over WB
module forward_unit
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] exe_src1,
  input  logic [REG_W-1:0] exe_src2,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b
);

  always_comb begin
    fwd_sel_a = FWD_REG;
    fwd_sel_b = FWD_REG;
    if (mem_wb_en && mem_dest == exe_src1)     fwd_sel_a = FWD_MEM;
    else if (wb_wb_en && wb_dest == exe_src1)  fwd_sel_a = FWD_WB;
    if (mem_wb_en && mem_dest == exe_src2)     fwd_sel_b = FWD_MEM;
    else if (wb_wb_en && wb_dest == exe_src2)  fwd_sel_b = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward controller with SRAM wait FSM and stall counter
// Optional operand bypassing enabled by FORWARDING_EN.
module pipeline_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  ctrl_state_e      state_q, state_d;
  logic             pending_br_q, pending_br_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic       raw_exe, raw_mem, hz_cand;
  logic       freeze_c, flush_c, hazard_c;
  logic [1:0] fwd_a, fwd_b;
  logic       unused_ok;

  always_comb begin
    raw_exe  = bus.exe_wb_en & ((bus.id_src1_vld & (bus.exe_dest == bus.id_src1)) |
                                (bus.id_src2_vld & (bus.exe_dest == bus.id_src2)));
    raw_mem  = bus.mem_wb_en & ((bus.id_src1_vld & (bus.mem_dest == bus.id_src1)) |
                                (bus.id_src2_vld & (bus.mem_dest == bus.id_src2)));
    freeze_c = bus.mem_req & ~bus.sram_ready;
    // A branch resolved under freeze is replayed as a flush on the first unfrozen cycle.
    flush_c  = ~freeze_c & (bus.branch_taken | pending_br_q);
`ifdef FORWARDING_EN
    hz_cand  = bus.exe_mem_r_en & raw_exe;
`else
    hz_cand  = raw_exe | raw_mem;
`endif
    hazard_c = hz_cand & ~flush_c & ~freeze_c;
  end

  always_comb begin
    state_d       = state_q;
    pending_br_d  = freeze_c ? (pending_br_q | bus.branch_taken) : 1'b0;
    stall_count_d = stall_count_q;
    case (state_q)
      ST_RUN:      if (freeze_c)  state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!freeze_c) state_d = ST_RUN;
      default:                    state_d = ST_RUN;
    endcase
    if ((hazard_c | freeze_c) && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      pending_br_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_br_q  <= pending_br_d;
      stall_count_q <= stall_count_d;
    end
  end

`ifdef FORWARDING_EN
  forward_unit #(.REG_W(REG_W)) u_fwd (
    .exe_src1  (bus.exe_src1),
    .exe_src2  (bus.exe_src2),
    .mem_dest  (bus.mem_dest),
    .mem_wb_en (bus.mem_wb_en),
    .wb_dest   (bus.wb_dest),
    .wb_wb_en  (bus.wb_wb_en),
    .fwd_sel_a (fwd_a),
    .fwd_sel_b (fwd_b)
  );
  assign unused_ok = raw_mem;
`else
  assign fwd_a     = FWD_REG;
  assign fwd_b     = FWD_REG;
  assign unused_ok = ^{bus.exe_mem_r_en, bus.exe_src1, bus.exe_src2, bus.wb_dest, bus.wb_wb_en};
`endif

  // Combinational outputs are gated so everything reads zero while reset is held.
  assign bus.hazard      = hazard_c & rst;
  assign bus.freeze      = freeze_c & rst;
  assign bus.flush       = flush_c & rst;
  assign bus.fwd_sel_a   = rst ? fwd_a : 2'b00;
  assign bus.fwd_sel_b   = rst ? fwd_b : 2'b00;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed plus randomized checks against a behavioural model
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  int   m_pending = 0;
  int   m_count   = 0;
  localparam int CNT_MAX = 65535;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) bus ();

  pipeline_hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_src1 = 0; bus.id_src1_vld = 0; bus.id_src2 = 0; bus.id_src2_vld = 0;
    bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
    bus.exe_src1 = 0; bus.exe_src2 = 0;
    bus.mem_dest = 0; bus.mem_wb_en = 0; bus.wb_dest = 0; bus.wb_wb_en = 0;
    bus.branch_taken = 0; bus.mem_req = 0; bus.sram_ready = 0;
  endtask

  task automatic rand_inputs();
    bus.id_src1 = 4'($urandom_range(0, 3)); bus.id_src1_vld = 1'($urandom);
    bus.id_src2 = 4'($urandom_range(0, 3)); bus.id_src2_vld = 1'($urandom);
    bus.exe_dest = 4'($urandom_range(0, 3)); bus.exe_wb_en = 1'($urandom);
    bus.exe_mem_r_en = 1'($urandom);
    bus.exe_src1 = 4'($urandom_range(0, 3)); bus.exe_src2 = 4'($urandom_range(0, 3));
    bus.mem_dest = 4'($urandom_range(0, 3)); bus.mem_wb_en = 1'($urandom);
    bus.wb_dest = 4'($urandom_range(0, 3)); bus.wb_wb_en = 1'($urandom);
    bus.branch_taken = ($urandom_range(0, 3) == 0);
    bus.mem_req = 1'($urandom);
    bus.sram_ready = ($urandom_range(0, 2) != 0);
  endtask

  // Does the producer (dest, wb_en) write a register the ID instruction reads?
  function automatic bit reads_from(input int dest, input bit wb_en);
    bit hit = 0;
    if (wb_en && bus.id_src1_vld && dest == int'(bus.id_src1)) hit = 1;
    if (wb_en && bus.id_src2_vld && dest == int'(bus.id_src2)) hit = 1;
    return hit;
  endfunction

  function automatic int fwd_of(input int src);
`ifdef FORWARDING_EN
    if (bus.mem_wb_en && int'(bus.mem_dest) == src) return 1;
    if (bus.wb_wb_en && int'(bus.wb_dest) == src) return 2;
`endif
    return 0;
  endfunction

  task automatic step(input string tag);
    bit e_frz, e_fl, e_hz, need;
    @(negedge clk);
    e_frz = bus.mem_req && !bus.sram_ready;
    e_fl  = !e_frz && (bus.branch_taken || m_pending != 0);
`ifdef FORWARDING_EN
    need  = bus.exe_mem_r_en && reads_from(int'(bus.exe_dest), bus.exe_wb_en);
`else
    need  = reads_from(int'(bus.exe_dest), bus.exe_wb_en) ||
            reads_from(int'(bus.mem_dest), bus.mem_wb_en);
`endif
    e_hz  = need && !e_frz && !e_fl;
    chk({tag, ".freeze"}, 32'(bus.freeze), 32'(e_frz));
    chk({tag, ".flush"},  32'(bus.flush),  32'(e_fl));
    chk({tag, ".hazard"}, 32'(bus.hazard), 32'(e_hz));
    chk({tag, ".fwd_a"},  32'(bus.fwd_sel_a), 32'(fwd_of(int'(bus.exe_src1))));
    chk({tag, ".fwd_b"},  32'(bus.fwd_sel_b), 32'(fwd_of(int'(bus.exe_src2))));
    chk({tag, ".count"},  32'(bus.stall_count), 32'(m_count));
    @(posedge clk);
    if (e_frz) m_pending = (m_pending != 0 || bus.branch_taken) ? 1 : 0;
    else       m_pending = 0;
    if ((e_hz || e_frz) && m_count < CNT_MAX) m_count++;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".hazard"}, 32'(bus.hazard), 0);
    chk({tag, ".freeze"}, 32'(bus.freeze), 0);
    chk({tag, ".flush"},  32'(bus.flush), 0);
    chk({tag, ".fwd_a"},  32'(bus.fwd_sel_a), 0);
    chk({tag, ".fwd_b"},  32'(bus.fwd_sel_b), 0);
    chk({tag, ".count"},  32'(bus.stall_count), 0);
  endtask

  initial begin
    clear_inputs();
    bus.mem_req = 1; bus.branch_taken = 1;
    bus.id_src1 = 3; bus.id_src1_vld = 1; bus.exe_dest = 3; bus.exe_wb_en = 1;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    clear_inputs();
    rst = 1;
    m_pending = 0; m_count = 0;

    // RAW against EXE (full stall without bypass, none with bypass and no load)
    bus.id_src1 = 3; bus.id_src1_vld = 1; bus.exe_dest = 3; bus.exe_wb_en = 1;
    step("raw_exe");
    clear_inputs();
    bus.exe_src1 = 3; bus.mem_dest = 3; bus.mem_wb_en = 1; bus.wb_dest = 3; bus.wb_wb_en = 1;
    bus.exe_src2 = 5; bus.wb_dest = 5;
    step("fwd_prio");
    clear_inputs();
    bus.id_src2 = 15; bus.id_src2_vld = 1; bus.exe_dest = 15; bus.exe_wb_en = 1;
    bus.exe_mem_r_en = 1;
    step("load_use_r15");
    clear_inputs();
    bus.id_src1 = 7; bus.id_src1_vld = 1; bus.mem_dest = 7; bus.mem_wb_en = 1;
    step("raw_mem");

    // three-cycle SRAM wait with a branch arriving mid-wait
    clear_inputs();
    bus.mem_req = 1;
    step("wait0");
    bus.branch_taken = 1;
    step("wait1");
    bus.branch_taken = 0;
    step("wait2");
    bus.sram_ready = 1;
    step("wait_done");
    bus.mem_req = 0; bus.sram_ready = 0;
    step("after_wait");

    // branch with a concurrent RAW hazard
    bus.branch_taken = 1;
    bus.id_src1 = 2; bus.id_src1_vld = 1; bus.exe_dest = 2; bus.exe_wb_en = 1;
    bus.exe_mem_r_en = 1;
    step("br_vs_raw");

    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step("rand");
    end

    // saturate the stall counter with a long freeze
    clear_inputs();
    bus.mem_req = 1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    m_count = CNT_MAX;
    m_pending = 0;
    step("sat0");
    bus.id_src1 = 1; bus.id_src1_vld = 1; bus.exe_dest = 1; bus.exe_wb_en = 1;
    bus.exe_mem_r_en = 1; bus.sram_ready = 1;
    step("sat1");
    step("sat2");

    // reset while waiting with a pending branch
    clear_inputs();
    bus.mem_req = 1; bus.branch_taken = 1;
    step("pre_rst");
    #2 rst = 0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk); #1;
    rst = 1;
    m_pending = 0; m_count = 0;
    clear_inputs();
    step("post_rst");
    step("post_rst2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
